// File: rtl/complete_stage.sv
// Completion buffer between the functional units and the ROB: results queue in
// FIFO order and up to three retire per cycle onto the ROB completion slots and the CDB.
module complete_stage #(
  parameter int DEPTH  = 8,
  parameter int FU_NUM = 4,
  parameter int ROB_W  = 6,
  parameter int XLEN   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FU_NUM-1:0]       fu_valid,
  input  logic [FU_NUM*ROB_W-1:0] fu_rob_idx,
  input  logic [FU_NUM*5-1:0]     fu_tag,
  input  logic [FU_NUM-1:0]       fu_mispredict,
  input  logic [FU_NUM*XLEN-1:0]  fu_target_pc,
  input  logic                    BPRecoverEN,
  output logic [FU_NUM-1:0]       fu_ready,
  output logic [2:0]              complete_valid,
  output logic [3*ROB_W-1:0]      complete_entry,
  output logic [2:0]              precise_state_valid,
  output logic [3*XLEN-1:0]       target_pc,
  output logic [2:0]              cdb_valid,
  output logic [3*5-1:0]          cdb_tag
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROB_W-1:0] buf_rob [DEPTH];
  logic [4:0]       buf_tag [DEPTH];
  logic             buf_mp  [DEPTH];
  logic [XLEN-1:0]  buf_pc  [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             ready;

  logic [FU_NUM-1:0] wr_en;
  logic [PTR_W-1:0]  wr_ptr [FU_NUM];
  logic [CNT_W-1:0]  n_push;
  logic [1:0]        n_pop;
  logic [PTR_W-1:0]  rd_ptr [3];

  // Acceptance depends on registered occupancy only, so a full burst always fits.
  assign ready     = (count <= CNT_W'(DEPTH - FU_NUM));
  assign fu_ready  = {FU_NUM{ready}};
  assign cdb_valid = complete_valid;

  // Stage boundary: pack accepted results onto consecutive tail slots, pick up to three pops
  always_comb begin
    n_push = '0;
    wr_en  = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      wr_ptr[i] = '0;
      if (ready && fu_valid[i]) begin
        wr_en[i]  = 1'b1;
        wr_ptr[i] = tail + n_push[PTR_W-1:0];
        n_push    = n_push + CNT_W'(1);
      end
    end
    n_pop = (count > CNT_W'(3)) ? 2'd3 : count[1:0];
    for (int j = 0; j < 3; j++) rd_ptr[j] = head + PTR_W'(j);
  end

  // Stage boundary: buffer update and registered completion/CDB slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      complete_valid      <= '0;
      precise_state_valid <= '0;
      complete_entry      <= '0;
      target_pc           <= '0;
      cdb_tag             <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_rob[k] <= '0;
        buf_tag[k] <= '0;
        buf_mp[k]  <= 1'b0;
        buf_pc[k]  <= '0;
      end
    end else if (BPRecoverEN) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      complete_valid      <= '0;
      precise_state_valid <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (wr_en[i]) begin
          buf_rob[wr_ptr[i]] <= fu_rob_idx[i*ROB_W +: ROB_W];
          buf_tag[wr_ptr[i]] <= fu_tag[i*5 +: 5];
          buf_mp[wr_ptr[i]]  <= fu_mispredict[i];
          buf_pc[wr_ptr[i]]  <= fu_target_pc[i*XLEN +: XLEN];
        end
      end
      tail  <= tail + n_push[PTR_W-1:0];
      head  <= head + PTR_W'(n_pop);
      count <= count + n_push - CNT_W'(n_pop);
      for (int j = 0; j < 3; j++) begin
        if (2'(j) < n_pop) begin
          complete_valid[j]                <= 1'b1;
          precise_state_valid[j]           <= buf_mp[rd_ptr[j]];
          complete_entry[j*ROB_W +: ROB_W] <= buf_rob[rd_ptr[j]];
          cdb_tag[j*5 +: 5]                <= buf_tag[rd_ptr[j]];
          target_pc[j*XLEN +: XLEN]        <= buf_mp[rd_ptr[j]] ? buf_pc[rd_ptr[j]] : '0;
        end else begin
          complete_valid[j]      <= 1'b0;
          precise_state_valid[j] <= 1'b0;
        end
      end
    end
  end
endmodule
